// File: rtl/fp_mul_if.sv
// Operand/result handshake bundle between the FP operand registers and the multiply sequencer.
interface fp_mul_if;
  logic        start;
  logic [11:0] x;
  logic [11:0] y;
  logic        ready;
  logic        done;
  logic [11:0] z;
  logic        ovf;
  logic        unf;

  modport master (output start, x, y, input ready, done, z, ovf, unf);
  modport slave  (input start, x, y, output ready, done, z, ovf, unf);
endinterface

// File: rtl/fp_mul_sequencer.sv
// Multi-cycle 12-bit FP multiply: shift-add significand product, normalise, exponent and range check.
//
// state  | meaning
// S_IDLE | waiting for start; ready=1 unless the done pulse is still showing
// S_MULT | one shift-add iteration per cycle, SIG_W cycles
// S_NORM | pick fraction bits depending on product MSB
// S_EXP  | biased exponent, over/underflow, write z
// S_DONE | raises done for the following cycle
// S_ZERO | zero operand bypass; writes signed zero, raises done
module fp_mul_sequencer #(
  parameter int EXP_W  = 4,
  parameter int FRAC_W = 7,
  parameter int BIAS   = 7
) (
  input logic     clk,
  input logic     rst_n,
  fp_mul_if.slave bus
);
  localparam int W      = 1 + EXP_W + FRAC_W;
  localparam int SIG_W  = FRAC_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int CNT_W  = $clog2(SIG_W);

  typedef enum logic [2:0] {
    S_IDLE, S_MULT, S_NORM, S_EXP, S_DONE, S_ZERO
  } state_t;

  state_t              state_q, state_d;
  logic [PROD_W-1:0]   mcand_q, mcand_d;
  logic [SIG_W-1:0]    mplier_q, mplier_d;
  logic [PROD_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EXP_W-1:0]    xe_q, xe_d, ye_q, ye_d;
  logic                sign_q, sign_d;
  logic                pm15_q, pm15_d;
  logic [FRAC_W-1:0]   frac_q, frac_d;
  logic [W-1:0]        z_q, z_d;
  logic                ovf_q, ovf_d, unf_q, unf_d;
  logic                done_q, done_d;
  logic                ready;
  logic signed [5:0]   e_s;

  // done is registered one cycle after DONE/ZERO; ready stays low while it shows
  assign ready     = (state_q == S_IDLE) && !done_q;
  assign bus.ready = ready;
  assign bus.done  = done_q;
  assign bus.z     = z_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      xe_q     <= '0;
      ye_q     <= '0;
      sign_q   <= 1'b0;
      pm15_q   <= 1'b0;
      frac_q   <= '0;
      z_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      xe_q     <= xe_d;
      ye_q     <= ye_d;
      sign_q   <= sign_d;
      pm15_q   <= pm15_d;
      frac_q   <= frac_d;
      z_q      <= z_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    xe_d     = xe_q;
    ye_d     = ye_q;
    sign_d   = sign_q;
    pm15_d   = pm15_q;
    frac_d   = frac_q;
    z_d      = z_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    done_d   = 1'b0;
    // 6-bit signed keeps the full range -7..24 without wrap
    e_s = $signed({2'b00, xe_q} + {2'b00, ye_q} + {5'b00000, pm15_q} - 6'(BIAS));

    case (state_q)
      S_IDLE: begin
        if (bus.start && ready) begin
          sign_d = bus.x[W-1] ^ bus.y[W-1];
          xe_d   = bus.x[W-2 -: EXP_W];
          ye_d   = bus.y[W-2 -: EXP_W];
          if (bus.x[W-2 -: EXP_W] == '0 || bus.y[W-2 -: EXP_W] == '0) begin
            state_d = S_ZERO;
          end else begin
            mcand_d  = {{SIG_W{1'b0}}, 1'b1, bus.x[FRAC_W-1:0]};
            mplier_d = {1'b1, bus.y[FRAC_W-1:0]};
            p_d      = '0;
            cnt_d    = '0;
            state_d  = S_MULT;
          end
        end
      end
      S_MULT: begin
        if (mplier_q[0]) p_d = p_q + (mcand_q << cnt_q);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SIG_W - 1)) state_d = S_NORM;
      end
      S_NORM: begin
        pm15_d  = p_q[PROD_W-1];
        frac_d  = p_q[PROD_W-1] ? p_q[PROD_W-2 -: FRAC_W] : p_q[PROD_W-3 -: FRAC_W];
        state_d = S_EXP;
      end
      S_EXP: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (e_s >= 6'sd15) begin
          ovf_d = 1'b1;
          z_d   = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (e_s <= 6'sd0) begin
          unf_d = 1'b1;
          z_d   = {sign_q, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
        end else begin
          z_d   = {sign_q, e_s[EXP_W-1:0], frac_q};
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ZERO: begin
        z_d     = {sign_q, {(W-1){1'b0}}};
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_mul_sequencer.sv
// Self-checking bench for fp_mul_sequencer: vector table, random ops vs arithmetic model, corner sequences.
module tb_fp_mul_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_mul_if bus();
  fp_mul_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: real-valued significand product, then the format rules
  task automatic ref_mul(input logic [11:0] xi, input logic [11:0] yi,
                         output logic [11:0] zo, output logic ovfo, output logic unfo,
                         output int lat);
    int xe, ye, prod, pm, fr, e;
    logic s;
    s  = xi[11] ^ yi[11];
    xe = int'(xi[10:7]);
    ye = int'(yi[10:7]);
    ovfo = 1'b0;
    unfo = 1'b0;
    if (xe == 0 || ye == 0) begin
      zo  = {s, 11'h000};
      lat = 1;
    end else begin
      prod = (128 + int'(xi[6:0])) * (128 + int'(yi[6:0]));
      pm   = (prod >= 32768) ? 1 : 0;
      fr   = (pm == 1) ? (prod / 256) % 128 : (prod / 128) % 128;
      e    = xe + ye - 7 + pm;
      lat  = 11;
      if (e >= 15) begin
        ovfo = 1'b1;
        zo   = {s, 4'hF, 7'h00};
      end else if (e <= 0) begin
        unfo = 1'b1;
        zo   = {s, 11'h000};
      end else begin
        zo   = {s, 4'(e), 7'(fr)};
      end
    end
  endtask

  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!bus.ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", {31'b0, bus.ready}, 32'd1);
  endtask

  task automatic run_op(input logic [11:0] xi, input logic [11:0] yi,
                        output logic [11:0] zo, output logic ovfo, output logic unfo,
                        output int lat);
    wait_ready();
    bus.start = 1'b1;
    bus.x = xi;
    bus.y = yi;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x = 12'($urandom);
    bus.y = 12'($urandom);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.done) break;
    end
    zo   = bus.z;
    ovfo = bus.ovf;
    unfo = bus.unf;
  endtask

  initial begin
    logic [11:0] z_a, z_r, zcap;
    logic ovf_a, unf_a, ovf_r, unf_r, ovfcap, rdycap;
    int lat_a, lat_r, ndone, first_done;

    tbl.push_back('{12'h380, 12'h380, 12'h380, 1'b0, 1'b0, 11});
    tbl.push_back('{12'h3C0, 12'h3C0, 12'h410, 1'b0, 1'b0, 11});
    tbl.push_back('{12'hB80, 12'h380, 12'hB80, 1'b0, 1'b0, 11});
    tbl.push_back('{12'h000, 12'h3C0, 12'h000, 1'b0, 1'b0, 1});
    tbl.push_back('{12'h700, 12'h700, 12'h780, 1'b1, 1'b0, 11});
    tbl.push_back('{12'h080, 12'h080, 12'h000, 1'b0, 1'b1, 11});
    tbl.push_back('{12'hB80, 12'h000, 12'h800, 1'b0, 1'b0, 1});
    tbl.push_back('{12'h200, 12'h200, 12'h080, 1'b0, 1'b0, 11});
    tbl.push_back('{12'h700, 12'h380, 12'h700, 1'b0, 1'b0, 11});
    tbl.push_back('{12'hFC0, 12'h380, 12'hF80, 1'b1, 1'b0, 11});

    bus.start = 1'b0;
    bus.x = 12'h000;
    bus.y = 12'h000;
    rst_n = 1'b0;
    #1;
    check("rst_ready", {31'b0, bus.ready}, 32'd1);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_z", {20'b0, bus.z}, 32'd0);
    check("rst_ovf", {31'b0, bus.ovf}, 32'd0);
    check("rst_unf", {31'b0, bus.unf}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].x, tbl[i].y, z_a, ovf_a, unf_a, lat_a);
      check($sformatf("vec%0d_z", i), {20'b0, z_a}, {20'b0, tbl[i].z});
      check($sformatf("vec%0d_ovf", i), {31'b0, ovf_a}, {31'b0, tbl[i].ovf});
      check($sformatf("vec%0d_unf", i), {31'b0, unf_a}, {31'b0, tbl[i].unf});
      check($sformatf("vec%0d_lat", i), lat_a, tbl[i].lat);
    end

    // result holds through idle, done is a single pulse
    repeat (3) @(posedge clk);
    #1;
    check("hold_z", {20'b0, bus.z}, 32'hF80);
    check("hold_ovf", {31'b0, bus.ovf}, 32'd1);
    check("hold_done", {31'b0, bus.done}, 32'd0);

    for (int n = 0; n < 150; n++) begin
      logic [11:0] xr, yr;
      xr = 12'($urandom);
      yr = 12'($urandom);
      run_op(xr, yr, z_a, ovf_a, unf_a, lat_a);
      ref_mul(xr, yr, z_r, ovf_r, unf_r, lat_r);
      check($sformatf("rnd%0d_z x=%h y=%h", n, xr, yr), {20'b0, z_a}, {20'b0, z_r});
      check($sformatf("rnd%0d_ovf", n), {31'b0, ovf_a}, {31'b0, ovf_r});
      check($sformatf("rnd%0d_unf", n), {31'b0, unf_a}, {31'b0, unf_r});
      check($sformatf("rnd%0d_lat", n), lat_a, lat_r);
    end

    // busy start at edges 3 and 11 must be ignored
    wait_ready();
    bus.start = 1'b1;
    bus.x = 12'h3C0;
    bus.y = 12'h3C0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    first_done = -1;
    zcap = '0;
    ovfcap = 1'b1;
    rdycap = 1'b1;
    for (int e = 1; e <= 25; e++) begin
      @(negedge clk);
      bus.start = (e == 3 || e == 11);
      bus.x = 12'h700;
      bus.y = 12'h700;
      @(posedge clk);
      #1;
      if (bus.done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = e;
          zcap = bus.z;
          ovfcap = bus.ovf;
          rdycap = bus.ready;
        end
      end
    end
    bus.start = 1'b0;
    check("busy_done_count", ndone, 1);
    check("busy_done_edge", first_done, 11);
    check("busy_z", {20'b0, zcap}, 32'h410);
    check("busy_ovf", {31'b0, ovfcap}, 32'd0);
    check("busy_ready_in_done", {31'b0, rdycap}, 32'd0);

    // reset in the middle of the multiply loop
    wait_ready();
    bus.start = 1'b1;
    bus.x = 12'h380;
    bus.y = 12'h700;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_z", {20'b0, bus.z}, 32'd0);
    check("midrst_ovf", {31'b0, bus.ovf}, 32'd0);
    check("midrst_done", {31'b0, bus.done}, 32'd0);
    check("midrst_ready", {31'b0, bus.ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(12'h380, 12'h3C0, z_a, ovf_a, unf_a, lat_a);
    ref_mul(12'h380, 12'h3C0, z_r, ovf_r, unf_r, lat_r);
    check("postrst_z", {20'b0, z_a}, {20'b0, z_r});
    check("postrst_lat", lat_a, lat_r);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
